// File: rtl/mem_access_ctrl.sv
// Memory access controller between the load/store stage and a 1024x32 word RAM.
// Handles byte/half/word loads and stores: read-modify-write for sub-word stores, extension for sub-word loads.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_str,
  output logic              ram_ld,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int unsigned BA_W = ADDR_W + 2;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [BA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              misaligned;

  // Select the addressed big-endian lane and extend it to a full word.
  function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] w, input logic [1:0] sz,
                                                 input logic sg, input logic [1:0] off);
    logic [7:0]        b;
    logic [15:0]       h;
    logic [DATA_W-1:0] r;
    b = w[7:0];
    case (off)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    h = off[1] ? w[15:0] : w[31:16];
    case (sz)
      SZ_BYTE: r = {{24{sg & b[7]}}, b};
      SZ_HALF: r = {{16{sg & h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace the addressed lane(s) of the old word with right-aligned store data.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w, input logic [DATA_W-1:0] d,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [DATA_W-1:0] r;
    r = w;
    if (sz == SZ_BYTE) begin
      case (off)
        2'd0:    r[31:24] = d[7:0];
        2'd1:    r[23:16] = d[7:0];
        2'd2:    r[15:8]  = d[7:0];
        default: r[7:0]   = d[7:0];
      endcase
    end else if (sz == SZ_HALF) begin
      if (off[1]) r[15:0]  = d[15:0];
      else        r[31:16] = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  always_comb begin
    misaligned = (req_size == 2'b11) ||
                 ((req_size == SZ_HALF) && req_addr[0]) ||
                 ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    din_d   = din_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        rdata_d = '0;
        err_d   = 1'b0;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          sgn_d   = req_signed;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned) begin
            state_d = S_RESP;
            err_d   = 1'b1;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_d = S_WR;
            din_d   = req_wdata;
          end else begin
            state_d = S_RD;
          end
        end
      end
      // Read data is consumed at the RD edge, so the merge uses the same word rd would hold.
      S_RD: begin
        if (we_q) begin
          din_d   = merge(ram_dout, wdata_q, size_q, addr_q[1:0]);
          state_d = S_WR;
        end else begin
          rdata_d = load_ext(ram_dout, size_q, sgn_q, addr_q[1:0]);
          state_d = S_RESP;
        end
      end
      S_WR: begin
        din_d   = '0;
        state_d = S_RESP;
      end
      default: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sgn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      din_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      din_q   <= din_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and RAM strobes decode straight from the state register.
  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign ram_ld     = (state_q == S_RD);
  assign ram_str    = (state_q == S_WR);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_addr   = addr_q[BA_W-1:2];
  assign ram_din    = din_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: byte-array reference memory plus a per-cycle schedule model.
module tb_mem_access_ctrl;
  localparam int unsigned AW = 10;

  logic          clk, rst_n;
  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW+1:0] req_addr;
  logic [31:0]   req_wdata, resp_rdata, ram_din, ram_dout;
  logic          resp_valid, resp_err, ram_str, ram_ld;
  logic [AW-1:0] ram_addr;

  mem_access_ctrl #(.ADDR_W(AW), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_str(ram_str), .ram_ld(ram_ld),
    .ram_dout(ram_dout)
  );

  logic [31:0] env_mem [0:1023];
  logic [7:0]  ref_mem [0:4095];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0;
  int acc_cnt = 0, resp_cnt = 0;
  int acc_cyc_log[$];
  int last_lat = 0;
  logic [31:0] last_rdata = '0;
  logic last_err = 1'b0;

  // Reference transaction in flight (cycle numbers count negedges)
  bit          busy = 0;
  int          t_acc, t_rd, t_wr, t_resp;
  logic [11:0] m_addr;
  logic [31:0] m_rdata, m_din;
  logic        m_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment RAM: combinational read gated by ld, write on rising edge under str.
  assign ram_dout = ram_ld ? env_mem[ram_addr] : 32'h0;
  initial begin
    for (int i = 0; i < 1024; i++) env_mem[i] = $urandom;
    forever begin
      @(posedge clk);
      if (ram_str) env_mem[ram_addr] <= ram_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] base_of(input logic [11:0] a);
    return {a[11:2], 2'b00};
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] sz, input logic sg);
    int v;
    v = 0;
    if (sz == 2'd0) begin
      v = int'(ref_mem[a]);
      if (sg && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = int'(ref_mem[a]) * 256 + int'(ref_mem[a + 12'd1]);
      if (sg && v >= 32768) v = v - 65536;
    end else begin
      return {ref_mem[base_of(a)], ref_mem[base_of(a) + 12'd1],
              ref_mem[base_of(a) + 12'd2], ref_mem[base_of(a) + 12'd3]};
    end
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_store_word(input logic [11:0] a, input logic [1:0] sz,
                                                 input logic [31:0] wd);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = ref_mem[base_of(a) + 12'(i)];
    if (sz == 2'd0) b[a[1:0]] = wd[7:0];
    else if (sz == 2'd1) begin
      b[a[1:0]]        = wd[15:8];
      b[a[1:0] + 2'd1] = wd[7:0];
    end else begin
      b[0] = wd[31:24]; b[1] = wd[23:16]; b[2] = wd[15:8]; b[3] = wd[7:0];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  // Compare process: checks every output on every negedge against the model schedule.
  initial begin
    bit exp_ld, exp_str, exp_rv, was_busy;
    logic [11:0] a;
    #1;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 4; k++) ref_mem[i*4 + k] = env_mem[i][31 - 8*k -: 8];
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ram_str", 32'(ram_str), 32'd0);
        chk("rst_ram_ld", 32'(ram_ld), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_din", ram_din, 32'd0);
        busy = 0;
      end else begin
        exp_ld  = busy && (cyc == t_rd);
        exp_str = busy && (cyc == t_wr);
        exp_rv  = busy && (cyc == t_resp);
        chk("req_ready", 32'(req_ready), 32'(!busy));
        chk("ram_ld", 32'(ram_ld), 32'(exp_ld));
        chk("ram_str", 32'(ram_str), 32'(exp_str));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        if (exp_ld || exp_str) chk("ram_addr", 32'(ram_addr), 32'(m_addr[11:2]));
        if (exp_str) begin
          chk("ram_din", ram_din, m_din);
          for (int k = 0; k < 4; k++) ref_mem[base_of(m_addr) + 12'(k)] = m_din[31 - 8*k -: 8];
        end
        if (exp_rv) begin
          chk("resp_rdata", resp_rdata, m_rdata);
          chk("resp_err", 32'(resp_err), 32'(m_err));
          last_rdata = resp_rdata;
          last_err   = resp_err;
          last_lat   = cyc - t_acc;
          resp_cnt++;
        end
        was_busy = busy;
        if (exp_rv) busy = 0;
        if (!was_busy && req_valid) begin
          a      = req_addr;
          m_addr = a;
          t_acc  = cyc;
          m_err  = (req_size == 2'd3) || (req_size == 2'd1 && a[0]) ||
                   (req_size == 2'd2 && a[1:0] != 2'd0);
          m_rdata = '0;
          m_din   = '0;
          t_rd = -1; t_wr = -1;
          if (m_err) t_resp = cyc + 1;
          else if (req_we && req_size == 2'd2) begin
            t_wr = cyc + 1; t_resp = cyc + 2;
            m_din = ref_store_word(a, req_size, req_wdata);
          end else if (req_we) begin
            t_rd = cyc + 1; t_wr = cyc + 2; t_resp = cyc + 3;
            m_din = ref_store_word(a, req_size, req_wdata);
          end else begin
            t_rd = cyc + 1; t_resp = cyc + 2;
            m_rdata = ref_load(a, req_size, req_signed);
          end
          busy = 1;
          acc_cnt++;
          acc_cyc_log.push_back(cyc);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [11:0] a, input logic [31:0] wd);
    int n0;
    n0 = acc_cnt;
    @(posedge clk); #1;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (acc_cnt != n0) break;
    end
    chk("accept_seen", 32'(acc_cnt != n0), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic txn(input logic we, input logic [1:0] sz, input logic sg, input logic [11:0] a,
                     input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
    int r0;
    r0 = resp_cnt;
    issue(we, sz, sg, a, wd);
    for (int i = 0; i < 50; i++) begin
      if (resp_cnt != r0) break;
      @(posedge clk); #1;
    end
    chk("resp_seen", 32'(resp_cnt != r0), 32'd1);
    rd = last_rdata; er = last_err; lat = last_lat;
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    int lat, a0, r0, l0, nmis;
    rst_n = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    txn(1, 2'd2, 0, 12'h010, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd2);
    txn(0, 2'd2, 0, 12'h010, 32'h0, rd, er, lat);
    chk("lw_data", rd, 32'hDEADBEEF);
    chk("lw_err", 32'(er), 32'd0);
    chk("lw_lat", 32'(lat), 32'd2);

    txn(1, 2'd2, 0, 12'h010, 32'h11223344, rd, er, lat);
    txn(1, 2'd0, 0, 12'h011, 32'h000000AA, rd, er, lat);
    chk("sb_lat", 32'(lat), 32'd3);
    txn(0, 2'd2, 0, 12'h010, 32'h0, rd, er, lat);
    chk("sb_merged", rd, 32'h11AA3344);

    txn(1, 2'd2, 0, 12'h010, 32'h11AA3380, rd, er, lat);
    txn(0, 2'd0, 1, 12'h013, 32'h0, rd, er, lat);
    chk("lb_signed", rd, 32'hFFFFFF80);
    txn(0, 2'd0, 0, 12'h013, 32'h0, rd, er, lat);
    chk("lbu", rd, 32'h00000080);
    txn(0, 2'd1, 1, 12'h012, 32'h0, rd, er, lat);
    chk("lh_signed", rd, 32'h00003380);

    txn(0, 2'd1, 0, 12'h001, 32'h0, rd, er, lat);
    chk("lh_mis_err", 32'(er), 32'd1);
    chk("lh_mis_rdata", rd, 32'h0);
    chk("lh_mis_lat", 32'(lat), 32'd1);
    txn(1, 2'd2, 0, 12'h002, 32'hCAFEF00D, rd, er, lat);
    chk("sw_mis_err", 32'(er), 32'd1);
    chk("sw_mis_lat", 32'(lat), 32'd1);

    // Reset in the WR cycle of a byte store must leave the RAM word untouched.
    txn(1, 2'd2, 0, 12'h020, 32'h11223344, rd, er, lat);
    issue(1, 2'd0, 0, 12'h021, 32'h00000055);
    @(posedge clk); #1;
    chk("wr_cycle_str", 32'(ram_str), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_str", 32'(ram_str), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ram_kept", env_mem[8], 32'h11223344);
    chk("rst_ready_after", 32'(req_ready), 32'd1);
    txn(0, 2'd2, 0, 12'h020, 32'h0, rd, er, lat);
    chk("rst_lw_after", rd, 32'h11223344);

    // req_valid held high: three word loads accepted back to back.
    a0 = acc_cnt; r0 = resp_cnt; l0 = acc_cyc_log.size();
    @(posedge clk); #1;
    req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 12'h010; req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (acc_cnt - a0 >= 3) break;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_cnt - r0 >= 3) break;
      @(posedge clk); #1;
    end
    chk("b2b_accepts", 32'(acc_cnt - a0), 32'd3);
    chk("b2b_resps", 32'(resp_cnt - r0), 32'd3);
    if (acc_cyc_log.size() >= l0 + 3) begin
      chk("b2b_gap0", 32'(acc_cyc_log[l0+1] - acc_cyc_log[l0]), 32'd3);
      chk("b2b_gap1", 32'(acc_cyc_log[l0+2] - acc_cyc_log[l0+1]), 32'd3);
    end

    // Random traffic, all checked cycle by cycle against the reference.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      req_valid  = ($urandom_range(0, 3) != 0);
      req_we     = 1'($urandom_range(0, 1));
      req_size   = 2'($urandom_range(0, 3));
      req_signed = 1'($urandom_range(0, 1));
      req_wdata  = $urandom;
      req_addr   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
    end
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    nmis = 0;
    for (int i = 0; i < 1024; i++)
      for (int k = 0; k < 4; k++)
        if (env_mem[i][31 - 8*k -: 8] !== ref_mem[i*4 + k]) nmis++;
    chk("ram_image_mismatches", 32'(nmis), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side memory access controller that sits between the CPU load/store stage and the 1024x32 word data RAM.
- Accepts byte, halfword and word load/store requests on a byte address through a valid/ready handshake.
- Drives the RAM's addr/D_in/str/ld pins, performing read-modify-write for sub-word stores and sign/zero extension for sub-word loads.
- Returns one response per request; misaligned accesses are flagged and never touch RAM.

Parameters:
- ADDR_W, 10, RAM word-address width; byte address width is ADDR_W+2.
- DATA_W, 32, RAM word width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request (high only in IDLE)
- req_we  input  1  1=store, 0=load
- req_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned)
- req_signed  input  1  sign-extend sub-word loads when 1
- req_addr  input  ADDR_W+2  byte address
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
- resp_valid  output  1  one-cycle pulse, response valid
- resp_rdata  output  32  load data, extended; 0 for stores/errors
- resp_err  output  1  misalignment/reserved-size flag, valid with resp_valid
- ram_addr  output  ADDR_W  word address = latched byte address[ADDR_W+1:2]
- ram_din  output  32  write data to RAM
- ram_str  output  1  RAM write strobe (RAM writes on rising clk edge while high)
- ram_ld  output  1  RAM read enable (RAM read data combinational, 0 when ld low)
- ram_dout  input  32  RAM read data

Behaviour:
- Byte lanes are big-endian: offset 0 = bits[31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0]; halfword offset 0 = [31:16], 2 = [15:0].
- FSM states: IDLE, RD, WR, RESP. ram_ld=1 only in RD; ram_str=1 only in WR; both are decoded from the state register.
- IDLE: req_ready=1. On req_valid, register we/size/signed/addr/wdata.
  - Next state: misaligned (half with addr[0]=1, word with addr[1:0]!=0, size=11) -> RESP with err.
  - Word store -> WR.
  - Everything else -> RD.
- RD: ram_ld=1. Latch ram_dout into rd_q at the edge. Load -> RESP; sub-word store -> WR.
- WR: ram_str=1, ram_din = merged word.
  - Word store: merged word = wdata.
  - Sub-word store: rd_q with the addressed lane(s) replaced by wdata[7:0] or [15:0].
  - Next state -> RESP.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE.
  - resp_rdata: selected lane, extended per req_signed (word unchanged); 0 for stores/errors.
  - resp_err as decoded.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles;
  - word store: 2 cycles;
  - sub-word store: 3 cycles;
  - error: 1 cycle.
- req_valid outside IDLE is ignored (not accepted). Back-to-back: a new request can be accepted in the cycle after RESP.
- ram_addr and ram_din are held stable for the full RD/WR cycle. ram_addr wraps naturally within ADDR_W bits; no bounds error is raised.
- Reset (any state, including mid-WR): state=IDLE immediately.
  - ram_str=0, ram_ld=0, resp_valid=0, resp_err=0, resp_rdata=0, ram_addr=0, ram_din=0, internal registers cleared.
  - A store interrupted before its WR edge is not performed.

Test Plan:
- Word store addr 0x010 data 0xDEADBEEF, then word load 0x010 -> ram_str high 1 cycle with ram_addr=4; load response 0xDEADBEEF, err=0, 2 cycles after accept.
- Byte store addr 0x011 data 0xAA over 0x11223344, then word load 0x010 -> RD then WR, ram_din=0x11AA3344; load returns 0x11AA3344; store latency 3.
- Loads from 0x013 holding 0x11AA3380: lb signed -> 0xFFFFFF80; lbu -> 0x00000080; lh signed 0x012 -> 0x00003380.
- Halfword load at 0x001 and word store at 0x002 -> resp_err=1, resp_rdata=0, ram_ld/ram_str never asserted, response 1 cycle after accept.
- Assert rst_n low during WR of a byte store -> ram_str drops asynchronously, RAM word unchanged, req_ready=1 after release.
- req_valid held high continuously with 3 word loads -> exactly 3 accepts, req_ready low during RD/RESP, one resp_valid pulse each.
